// File: rtl/vslc_spi_fetch.sv
// vslc_spi_fetch: address-strobe fetch responder for the VSLC core.
// On an accepted addr_strobe it reads one byte from SPI NOR flash using a
// READ command (RD_CMD, 24-bit address ADDR_BASE+addr, 8 data bits) in SPI
// mode 0. The byte is returned on data with a one-cycle data_valid pulse.
// Optional build macro: VSLC_FETCH_CACHE_EN adds a one-entry byte cache.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   addr_strobe, addr   request pulse and 8-bit program address
//   data, data_valid    fetched byte and its one-cycle valid pulse
//   busy                request in flight (through the data_valid cycle)
//   spi_cs_n, spi_sck,
//   spi_mosi, spi_miso  flash pins (mode 0, MSB first)
module vslc_spi_fetch #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [23:0] ADDR_BASE = 24'h000000,
    parameter logic [7:0]  RD_CMD    = 8'h03
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       addr_strobe,
    input  logic [7:0] addr,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       busy,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = 6;
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_CMD  = BIT_W'(7);
    localparam logic [BIT_W-1:0] LAST_ADDR = BIT_W'(31);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(39);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [31:0]       sreg_q, sreg_d;   // bits still to send, next bit at [31]
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        data_q, data_d;
    logic              dv_q, dv_d;
    logic              busy_q, busy_d;
    logic              cs_n_q, cs_n_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
`ifdef VSLC_FETCH_CACHE_EN
    logic [7:0]        addr_q, addr_d;
    logic              c_valid_q, c_valid_d;
    logic [7:0]        c_tag_q, c_tag_d;
    logic [7:0]        c_byte_q, c_byte_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            sreg_q    <= '0;
            rx_q      <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
`ifdef VSLC_FETCH_CACHE_EN
            addr_q    <= '0;
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_byte_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            sreg_q    <= sreg_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
`ifdef VSLC_FETCH_CACHE_EN
            addr_q    <= addr_d;
            c_valid_q <= c_valid_d;
            c_tag_q   <= c_tag_d;
            c_byte_q  <= c_byte_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        rx_d      = rx_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        busy_d    = busy_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
`ifdef VSLC_FETCH_CACHE_EN
        addr_d    = addr_q;
        c_valid_d = c_valid_q;
        c_tag_d   = c_tag_q;
        c_byte_d  = c_byte_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (addr_strobe) begin
`ifdef VSLC_FETCH_CACHE_EN
                    addr_d = addr;
                    if (c_valid_q && (c_tag_q == addr)) begin
                        // Hit: answer next cycle without touching the flash
                        state_d = S_DONE;
                        data_d  = c_byte_q;
                        dv_d    = 1'b1;
                        busy_d  = 1'b1;
                    end else
`endif
                    begin
                        // First bit (RD_CMD[7]) goes straight to mosi; rest queued
                        state_d = S_CMD;
                        ph_d    = '0;
                        bit_d   = '0;
                        sreg_d  = {RD_CMD[6:0], ADDR_BASE + 24'(addr), 1'b0};
                        cs_n_d  = 1'b0;
                        sck_d   = 1'b0;
                        mosi_d  = RD_CMD[7];
                        busy_d  = 1'b1;
                    end
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (ph_q != PH_LAST) begin
                    ph_d = ph_q + PH_W'(1);
                end else begin
                    ph_d = '0;
                    if (!sck_q) begin
                        // Rising edge: flash data sampled here
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], spi_miso};
                    end else if (bit_q == LAST_BIT) begin
                        state_d = S_DONE;
                        cs_n_d  = 1'b1;
                        sck_d   = 1'b0;
                        mosi_d  = 1'b0;
                        data_d  = rx_q;
                        dv_d    = 1'b1;
`ifdef VSLC_FETCH_CACHE_EN
                        c_valid_d = 1'b1;
                        c_tag_d   = addr_q;
                        c_byte_d  = rx_q;
`endif
                    end else begin
                        // Falling edge: advance to the next bit
                        sck_d  = 1'b0;
                        bit_d  = bit_q + BIT_W'(1);
                        sreg_d = {sreg_q[30:0], 1'b0};
                        mosi_d = (bit_q >= LAST_ADDR) ? 1'b0 : sreg_q[31];
                        if (bit_q == LAST_CMD) begin
                            state_d = S_ADDR;
                        end else if (bit_q == LAST_ADDR) begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_vslc_spi_fetch.sv
// Directed bench for vslc_spi_fetch: three instances with different
// CLK_DIV/ADDR_BASE share one behavioural SPI flash, selected by sel.
module tb_vslc_spi_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] strobe_v;
    logic [7:0] addr_in;
    logic       miso = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [7:0] data_v [3];
    logic [2:0] dv_v, busy_v, cs_v, sck_v, mosi_v;

    vslc_spi_fetch #(.CLK_DIV(2), .ADDR_BASE(24'h000000), .RD_CMD(8'h03)) u0 (
        .clk(clk), .rst_n(rst_n), .addr_strobe(strobe_v[0]), .addr(addr_in),
        .data(data_v[0]), .data_valid(dv_v[0]), .busy(busy_v[0]), .spi_cs_n(cs_v[0]),
        .spi_sck(sck_v[0]), .spi_mosi(mosi_v[0]), .spi_miso(miso));
    vslc_spi_fetch #(.CLK_DIV(2), .ADDR_BASE(24'h010000), .RD_CMD(8'h03)) u1 (
        .clk(clk), .rst_n(rst_n), .addr_strobe(strobe_v[1]), .addr(addr_in),
        .data(data_v[1]), .data_valid(dv_v[1]), .busy(busy_v[1]), .spi_cs_n(cs_v[1]),
        .spi_sck(sck_v[1]), .spi_mosi(mosi_v[1]), .spi_miso(miso));
    vslc_spi_fetch #(.CLK_DIV(1), .ADDR_BASE(24'hFFFFFF), .RD_CMD(8'h03)) u2 (
        .clk(clk), .rst_n(rst_n), .addr_strobe(strobe_v[2]), .addr(addr_in),
        .data(data_v[2]), .data_valid(dv_v[2]), .busy(busy_v[2]), .spi_cs_n(cs_v[2]),
        .spi_sck(sck_v[2]), .spi_mosi(mosi_v[2]), .spi_miso(miso));

    logic [7:0] data_m;
    logic dv_m, busy_m, cs_m, sck_m, mosi_m;
    assign data_m = data_v[sel];
    assign dv_m   = dv_v[sel];
    assign busy_m = busy_v[sel];
    assign cs_m   = cs_v[sel];
    assign sck_m  = sck_v[sel];
    assign mosi_m = mosi_v[sel];

    // Flash contents: a few fixed bytes, pattern elsewhere
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h5A;
            24'h000003: return 8'hC3;
            24'h000005: return 8'hA5;
            24'h000008: return 8'h3C;
            24'h000010: return 8'h96;
            24'h010007: return 8'h7E;
            default:    return a[7:0] ^ 8'hE1;
        endcase
    endfunction

    // SPI flash model: collects command/address on SCK rise, drives data on fall
    int         bit_cnt = 0;
    logic [31:0] rx_sh = '0;
    logic [7:0] cap_cmd = '0;
    logic [23:0] cap_addr = '0;
    logic       data_mosi_seen = 1'b0;
    logic [7:0] fb;
    assign fb = flash_byte(cap_addr);

    always @(posedge sck_m or negedge cs_m) begin
        if (!sck_m) begin
            bit_cnt        <= 0;
            data_mosi_seen <= 1'b0;
        end else begin
            rx_sh   <= {rx_sh[30:0], mosi_m};
            bit_cnt <= bit_cnt + 1;
            if (bit_cnt == 31) begin
                cap_cmd  <= rx_sh[30:23];
                cap_addr <= {rx_sh[22:0], mosi_m};
            end
            if (bit_cnt >= 32 && mosi_m) data_mosi_seen <= 1'b1;
        end
    end

    always @(negedge sck_m) begin
        if (!cs_m && bit_cnt >= 32 && bit_cnt < 40) miso <= fb[3'(39 - bit_cnt)];
    end

    // Cycle counters: CS-low run length, transactions started, data_valid pulses
    int   cs_low = 0, txn_cnt = 0, dv_cnt = 0;
    logic cs_prev = 1'b1;
    always @(posedge clk) begin
        if (!cs_m) cs_low <= cs_prev ? 1 : cs_low + 1;
        if (cs_prev && !cs_m) txn_cnt <= txn_cnt + 1;
        if (dv_m) dv_cnt <= dv_cnt + 1;
        cs_prev <= cs_m;
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after acceptance
    task automatic start(input logic [7:0] a);
        strobe_v = 3'b001 << sel;
        addr_in  = a;
        @(negedge clk);
        strobe_v = '0;
    endtask

    // Waits (bounded) for data_valid; lat is the cycle number where it is seen
    task automatic wait_valid(input int first, output int lat);
        lat = first;
        while (!dv_m && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, dv0, tx0;

    initial begin
        strobe_v = '0;
        addr_in  = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_m), 32'h0);
        check("rst_dv", 32'(dv_m), 32'h0);
        check("rst_busy", 32'(busy_m), 32'h0);
        check("rst_cs_n", 32'(cs_m), 32'h1);
        check("rst_sck", 32'(sck_m), 32'h0);
        check("rst_mosi", 32'(mosi_m), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic fetch, CLK_DIV=2, base 0
        sel = 2'd0; dv0 = dv_cnt; tx0 = txn_cnt;
        start(8'h05);
        check("t1_c1_cs_n", 32'(cs_m), 32'h0);
        check("t1_c1_busy", 32'(busy_m), 32'h1);
        check("t1_c1_sck", 32'(sck_m), 32'h0);
        check("t1_c1_mosi", 32'(mosi_m), 32'h0);
        wait_valid(1, lat);
        check("t1_latency", 32'(lat), 32'd161);
        check("t1_data", 32'(data_m), 32'hA5);
        check("t1_busy_done", 32'(busy_m), 32'h1);
        check("t1_cs_done", 32'(cs_m), 32'h1);
        check("t1_cs_low", 32'(cs_low), 32'd160);
        check("t1_cmd", 32'(cap_cmd), 32'h03);
        check("t1_addr", 32'(cap_addr), 32'h000005);
        check("t1_sck_pulses", 32'(bit_cnt), 32'd40);
        check("t1_mosi_data0", 32'(data_mosi_seen), 32'h0);
        @(negedge clk);
        check("t1_busy_after", 32'(busy_m), 32'h0);
        check("t1_dv_after", 32'(dv_m), 32'h0);
        check("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("t1_txn_count", 32'(txn_cnt - tx0), 32'd1);

        // 2: ADDR_BASE=0x010000
        sel = 2'd1;
        @(negedge clk);
        start(8'h07);
        wait_valid(1, lat);
        check("t2_latency", 32'(lat), 32'd161);
        check("t2_addr", 32'(cap_addr), 32'h010007);
        check("t2_data", 32'(data_m), 32'h7E);
        @(negedge clk);

        // 3: strobe while busy is ignored
        sel = 2'd0; dv0 = dv_cnt; tx0 = txn_cnt;
        @(negedge clk);
        start(8'h10);
        repeat (39) @(negedge clk);
        start(8'h20);
        wait_valid(41, lat);
        check("t3_latency", 32'(lat), 32'd161);
        check("t3_addr", 32'(cap_addr), 32'h000010);
        check("t3_data", 32'(data_m), 32'h96);
        repeat (200) @(negedge clk);
        check("t3_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("t3_txn_count", 32'(txn_cnt - tx0), 32'd1);
        check("t3_busy_idle", 32'(busy_m), 32'h0);

        // 4: reset mid-fetch, then a clean fetch
        start(8'h30);
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_rst_cs_n", 32'(cs_m), 32'h1);
        check("t4_rst_sck", 32'(sck_m), 32'h0);
        check("t4_rst_busy", 32'(busy_m), 32'h0);
        check("t4_rst_dv", 32'(dv_m), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start(8'h03);
        wait_valid(1, lat);
        check("t4_latency", 32'(lat), 32'd161);
        check("t4_addr", 32'(cap_addr), 32'h000003);
        check("t4_data", 32'(data_m), 32'hC3);
        @(negedge clk);

        // 5: CLK_DIV=1, base 0xFFFFFF (address wrap), back-to-back requests
        sel = 2'd2;
        @(negedge clk);
        start(8'h01);
        wait_valid(1, lat);
        check("t5_latency", 32'(lat), 32'd81);
        check("t5_cs_low", 32'(cs_low), 32'd80);
        check("t5_sck_pulses", 32'(bit_cnt), 32'd40);
        check("t5_addr", 32'(cap_addr), 32'h000000);
        check("t5_data", 32'(data_m), 32'h5A);
        @(negedge clk);
        check("t5_busy_idle", 32'(busy_m), 32'h0);
        start(8'h02);
        check("t5_b2b_cs_n", 32'(cs_m), 32'h0);
        wait_valid(1, lat);
        check("t5_b2b_latency", 32'(lat), 32'd81);
        check("t5_wrap_addr", 32'(cap_addr), 32'h000001);
        check("t5_wrap_data", 32'(data_m), 32'hE0);
        @(negedge clk);

        // 6: repeated address (cache hit when enabled), then a different one
        sel = 2'd0;
        @(negedge clk);
        start(8'h08);
        wait_valid(1, lat);
        check("t6_fill_latency", 32'(lat), 32'd161);
        check("t6_fill_data", 32'(data_m), 32'h3C);
        @(negedge clk);
        tx0 = txn_cnt;
        start(8'h08);
        wait_valid(1, lat);
        check("t6_rep_data", 32'(data_m), 32'h3C);
`ifdef VSLC_FETCH_CACHE_EN
        check("t6_hit_latency", 32'(lat), 32'd1);
        check("t6_hit_busy", 32'(busy_m), 32'h1);
        check("t6_hit_txn", 32'(txn_cnt - tx0), 32'd0);
        @(negedge clk);
        check("t6_hit_busy_after", 32'(busy_m), 32'h0);
`else
        check("t6_rep_latency", 32'(lat), 32'd161);
        check("t6_rep_txn", 32'(txn_cnt - tx0), 32'd1);
        @(negedge clk);
`endif
        start(8'h09);
        wait_valid(1, lat);
        check("t6_miss_latency", 32'(lat), 32'd161);
        check("t6_miss_addr", 32'(cap_addr), 32'h000009);
        check("t6_miss_data", 32'(data_m), 32'hE8);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
